// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: digit-serial adder/subtractor with start/busy/done handshake.
// Each RUN cycle pushes DIGIT bits of A, B and the running carry through a
// ripple full-add slice; the full result is published on s/cout/ovf only when
// the DONE state is entered, so partial sums are never visible.
// Optional build macro: SERIAL_ADD_SAT_EN. When defined, an overflowing result
// is replaced by the signed saturation value in the direction of a's MSB.
module serial_adder_fsm #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic                   accept_s;
  logic                   last_s;
  logic [DIGIT-1:0]       sum_s;
  logic [DIGIT:0]         c_s;
  logic [WIDTH+DIGIT-1:0] res_cat_s;
  logic [WIDTH-1:0]       res_next_s;
  logic                   ovf_next_s;
  logic [WIDTH-1:0]       s_next_s;

`ifdef SERIAL_ADD_SAT_EN
  logic a_msb_r;

  // Most positive value for a non-negative a, most negative value otherwise.
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    logic [WIDTH-1:0] v;
    if (neg) begin
      v = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      v = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return v;
  endfunction
`endif

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s   = (cnt_r == CNT_LAST);

  // Next-state decode; start is only honoured outside RUN.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Ripple full-add slice over the low DIGIT bits plus the result shift and
  // the final-digit overflow term (carry out of vs. carry into the MSB).
  always_comb begin
    c_s        = '0;
    sum_s      = '0;
    c_s[0]     = carry_r;
    for (int i = 0; i < DIGIT; i++) begin
      sum_s[i]   = a_r[i] ^ b_r[i] ^ c_s[i];
      c_s[i+1]   = (a_r[i] & b_r[i]) | (c_s[i] & (a_r[i] ^ b_r[i]));
    end
    res_cat_s  = {sum_s, res_r};
    res_next_s = res_cat_s[WIDTH+DIGIT-1:DIGIT];
    ovf_next_s = c_s[DIGIT] ^ c_s[DIGIT-1];
`ifdef SERIAL_ADD_SAT_EN
    if (ovf_next_s) begin
      s_next_s = sat_value(a_msb_r);
    end else begin
      s_next_s = res_next_s;
    end
`else
    s_next_s   = res_next_s;
`endif
  end

  // State register plus busy/done flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Operand/carry/result shift registers and digit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else if (accept_s) begin
      // Subtraction is a + ~b + ~cin, so B and the carry are inverted at load.
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      res_r   <= '0;
      carry_r <= cin ^ sub;
      cnt_r   <= '0;
    end else if (state_r == RUN) begin
      a_r     <= a_r >> DIGIT;
      b_r     <= b_r >> DIGIT;
      res_r   <= res_next_s;
      carry_r <= c_s[DIGIT];
      cnt_r   <= cnt_r + CNT_W'(1);
    end else begin
      a_r     <= a_r;
      b_r     <= b_r;
      res_r   <= res_r;
      carry_r <= carry_r;
      cnt_r   <= cnt_r;
    end
  end

`ifdef SERIAL_ADD_SAT_EN
  // Operand sign kept separately because a_r is shifted away during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_r <= 1'b0;
    end else if (accept_s) begin
      a_msb_r <= a[WIDTH-1];
    end else begin
      a_msb_r <= a_msb_r;
    end
  end
`endif

  // Published result: updated only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if ((state_r == RUN) && last_s) begin
      s_r    <= s_next_s;
      cout_r <= c_s[DIGIT];
      ovf_r  <= ovf_next_s;
    end else begin
      s_r    <= s_r;
      cout_r <= cout_r;
      ovf_r  <= ovf_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign s    = s_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm: a bit-serial (DIGIT=1) and a
// nibble-serial (DIGIT=4) instance checked against an integer-arithmetic model.
module tb_serial_adder_fsm;

  logic       clk;
  logic       rst;
  logic       start1;
  logic       start4;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;

  logic       busy1, done1, cout1, ovf1;
  logic [7:0] s1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] s4;

  int total = 0;
  int bad   = 0;

  serial_adder_fsm #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder_fsm #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                input logic mcin, input logic msub,
                                output logic [7:0] es, output logic ec, output logic eo);
    int ua, ub, ia, ib, ci, ur, sr;
    ua = ma; ub = mb; ia = $signed(ma); ib = $signed(mb); ci = mcin;
    if (msub) begin
      ur = ua - ub - ci;
      sr = ia - ib - ci;
      ec = (ur >= 0);
    end else begin
      ur = ua + ub + ci;
      sr = ia + ib + ci;
      ec = (ur > 255);
    end
    es = ur[7:0];
    eo = (sr > 127) || (sr < -128);
`ifdef SERIAL_ADD_SAT_EN
    if (eo) es = ma[7] ? 8'h80 : 8'h7F;
`endif
  endfunction

  function automatic logic get_done(input int inst);
    return (inst == 1) ? done1 : done4;
  endfunction
  function automatic logic get_busy(input int inst);
    return (inst == 1) ? busy1 : busy4;
  endfunction

  // One operation from an idle DUT; optional stray start on instance 1 at RUN cycle 'glitch'.
  task automatic do_op(input int inst, input logic [7:0] ta, input logic [7:0] tbv,
                       input logic tcin, input logic tsub, input string tag, input int glitch);
    logic [7:0] es, gs;
    logic ec, eo, gc, go;
    int lat, nb, n;
    n = (inst == 1) ? 8 : 2;
    model(ta, tbv, tcin, tsub, es, ec, eo);
    @(negedge clk);
    a = ta; b = tbv; cin = tcin; sub = tsub;
    if (inst == 1) start1 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    lat = 0; nb = 0;
    while (!get_done(inst) && lat < 40) begin
      if (get_busy(inst)) nb++;
      if (lat == glitch) begin
        start1 = 1'b1; a = ~ta; b = 8'h55; sub = ~tsub;
      end else begin
        start1 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start1 = 1'b0;
    gs = (inst == 1) ? s1 : s4;
    gc = (inst == 1) ? cout1 : cout4;
    go = (inst == 1) ? ovf1 : ovf4;
    chk({tag, "_lat"}, lat, n);
    chk({tag, "_busycyc"}, nb, n);
    chk({tag, "_s"}, gs, es);
    chk({tag, "_cout"}, gc, ec);
    chk({tag, "_ovf"}, go, eo);
    @(posedge clk); #1;
    chk({tag, "_donepulse"}, get_done(inst), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra, rb;
    logic rc, rs;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_s", s1, 8'h00);
    chk("rst_cout_ovf", {cout1, ovf1}, 2'b00);
    rst = 1'b0;

    // Directed cases on the bit-serial instance.
    do_op(1, 8'h3C, 8'h0F, 1'b0, 1'b0, "add_3c_0f", -1);
    do_op(1, 8'hFF, 8'h01, 1'b1, 1'b0, "add_ff_01_c", -1);
    do_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf", -1);
    do_op(1, 8'h05, 8'h07, 1'b0, 1'b1, "sub_05_07", -1);
    do_op(1, 8'h80, 8'h01, 1'b0, 1'b1, "sub_ovf", -1);

    // Stray start in RUN cycle 3 must be ignored.
    do_op(1, 8'h3C, 8'h0F, 1'b0, 1'b0, "glitch", 2);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun_busy", busy1, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy1, 1'b0);
    chk("arst_done", done1, 1'b0);
    chk("arst_s", s1, 8'h00);
    chk("arst_cout_ovf", {cout1, ovf1}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    do_op(1, 8'h12, 8'h34, 1'b0, 1'b0, "after_rst", -1);

    // Nibble-serial back-to-back with start held in DONE.
    do_op(4, 8'h7F, 8'h01, 1'b0, 1'b0, "d4_ovf", -1);
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; cin = 1'b0; sub = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("b2b_busy0", busy4, 1'b1);
    @(posedge clk); #1;
    chk("b2b_busy1", {busy4, done4}, 2'b10);
    @(posedge clk); #1;
    chk("b2b_done1", {busy4, done4}, 2'b01);
    chk("b2b_s1", s4, 8'h4B);
    a = 8'h10; b = 8'h20; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("b2b_nogap", {busy4, done4}, 2'b10);
    chk("b2b_hold", s4, 8'h4B);
    @(posedge clk); #1;
    chk("b2b_run2", {busy4, done4}, 2'b10);
    @(posedge clk); #1;
    chk("b2b_done2", {busy4, done4}, 2'b01);
    chk("b2b_s2", s4, 8'h30);
    @(posedge clk); #1;
    chk("b2b_idle", {busy4, done4}, 2'b00);

    // Randomized operations on both instances.
    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      do_op(1, ra, rb, rc, rs, "rnd1", -1);
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      do_op(4, ra, rb, rc, rs, "rnd4", -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
